corr_window_energy_param: RTL and testbench

CORR_WINDOW_ENERGY_PARAM -- requirements
Module: corr_window_energy_param

---
 rtl/corr_window_energy_param.sv | 228 ++++++++++++++++++++++
 tb/tb_corr_window_energy_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/corr_window_energy_param.sv
// -----------------------------------------------------------------------------
// corr_window_energy_param
//
// Sliding-window energy accumulator for a complex I/Q sample stream. Each
// valid sample contributes Re^2 + Im^2. The block outputs the sum of the
// last WIN = 2^WIN_LOG2 energies, and can optionally delay that sum by DELAY
// valid samples.
//
// Pipeline: energy (1) -> running sum (2) -> output / delay line (3).
// An input accepted in cycle c produces OutputEnable in cycle c+3.
//
// Parameters:
//   DW        signed width of each I/Q sample
//   WIN_LOG2  log2 of the window length (1..8)
//   DELAY     output delay in valid samples (0..64, 0 = none)
//
// Ports:
//   Clk           rising-edge clock
//   Rst_n         asynchronous active-low reset
//   InputEnable   DataInARe/DataInAIm valid this cycle
//   DataInARe     real part, two's complement
//   DataInAIm     imaginary part, two's complement
//   OutputEnable  one-cycle pulse per emitted result
//   SumMagnitude  unsigned windowed energy sum, held between pulses
//   WindowFull    high once WIN valid samples have entered the window
//
// Build option:
//   CWE_WINDOW_GATE_EN  when defined, results are emitted only once the
//                       window is full; the delay line still shifts.
// -----------------------------------------------------------------------------
module corr_window_energy_param #(
    parameter int DW       = 8,
    parameter int WIN_LOG2 = 4,
    parameter int DELAY    = 0
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       InputEnable,
    input  logic [DW-1:0]              DataInARe,
    input  logic [DW-1:0]              DataInAIm,
    output logic                       OutputEnable,
    output logic [2*DW+WIN_LOG2:0]     SumMagnitude,
    output logic                       WindowFull
);

    localparam int EW  = 2*DW + 1;
    localparam int SW  = 2*DW + 1 + WIN_LOG2;
    localparam int WIN = 1 << WIN_LOG2;

    localparam logic [WIN_LOG2-1:0] PTR_ONE = WIN_LOG2'(1);
    localparam logic [WIN_LOG2:0]   CNT_ONE = (WIN_LOG2+1)'(1);
    localparam logic [WIN_LOG2:0]   CNT_WIN = (WIN_LOG2+1)'(WIN);

    // ---------------- stage 1: energy ----------------
    // The samples are sign-extended to 2*DW bits. The low 2*DW bits of the
    // product are the same whether the multiply is signed or unsigned, and a
    // square is never negative.
    logic [2*DW-1:0] reExt_s;
    logic [2*DW-1:0] imExt_s;
    logic [2*DW-1:0] reSq_s;
    logic [2*DW-1:0] imSq_s;
    logic [EW-1:0]   energy_s;
    logic [EW-1:0]   energy_r;
    logic            v1_r;

    // Squares and energy of the incoming sample
    always_comb begin
        reExt_s  = {{DW{DataInARe[DW-1]}}, DataInARe};
        imExt_s  = {{DW{DataInAIm[DW-1]}}, DataInAIm};
        reSq_s   = reExt_s * reExt_s;
        imSq_s   = imExt_s * imExt_s;
        energy_s = {1'b0, reSq_s} + {1'b0, imSq_s};
    end

    // Stage-1 energy register and valid flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            energy_r <= {EW{1'b0}};
            v1_r     <= 1'b0;
        end else begin
            v1_r <= InputEnable;
            if (InputEnable) begin
                energy_r <= energy_s;
            end else begin
                energy_r <= energy_r;
            end
        end
    end

    // ---------------- stage 2: circular buffer + running sum ----------------
    logic [EW-1:0]       energyBuf_r [WIN];
    logic [WIN_LOG2-1:0] wrPtr_r;
    logic [SW-1:0]       acc_r;
    logic [SW-1:0]       accNext_s;
    logic [WIN_LOG2:0]   fillCount_r;
    logic [WIN_LOG2:0]   fillNext_s;
    logic                v2_r;
    logic                full2_r;

    // Add the new energy and drop the one being overwritten. Empty slots hold
    // zero, so a partial window needs no special case. The result never goes
    // negative because the dropped entry is part of acc_r.
    always_comb begin
        accNext_s = acc_r + {{WIN_LOG2{1'b0}}, energy_r}
                          - {{WIN_LOG2{1'b0}}, energyBuf_r[wrPtr_r]};
        if (fillCount_r == CNT_WIN) begin
            fillNext_s = fillCount_r;
        end else begin
            fillNext_s = fillCount_r + CNT_ONE;
        end
    end

    // Window state advances only on valid stage-1 data
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                energyBuf_r[i] <= {EW{1'b0}};
            end
            wrPtr_r     <= {WIN_LOG2{1'b0}};
            acc_r       <= {SW{1'b0}};
            fillCount_r <= {(WIN_LOG2+1){1'b0}};
            full2_r     <= 1'b0;
            v2_r        <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                energyBuf_r[wrPtr_r] <= energy_r;
                wrPtr_r              <= wrPtr_r + PTR_ONE;
                acc_r                <= accNext_s;
                fillCount_r          <= fillNext_s;
                full2_r              <= (fillNext_s == CNT_WIN);
            end else begin
                wrPtr_r     <= wrPtr_r;
                acc_r       <= acc_r;
                fillCount_r <= fillCount_r;
                full2_r     <= full2_r;
            end
        end
    end

    // ---------------- stage 3: output (optional delay line) ----------------
    logic gateOk_s;

    // Decide whether partial-window results may be emitted
    always_comb begin
`ifdef CWE_WINDOW_GATE_EN
        gateOk_s = full2_r;
`else
        gateOk_s = 1'b1;
`endif
    end

    generate
        if (DELAY == 0) begin : gNoDelay
            logic outPulse_s;

            // Emit the current window sum whenever stage 2 holds a valid result
            always_comb begin
                outPulse_s = v2_r & gateOk_s;
            end

            // Output register: the sum is held between pulses
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    OutputEnable <= 1'b0;
                    SumMagnitude <= {SW{1'b0}};
                    WindowFull   <= 1'b0;
                end else begin
                    OutputEnable <= outPulse_s;
                    WindowFull   <= full2_r;
                    if (outPulse_s) begin
                        SumMagnitude <= acc_r;
                    end else begin
                        SumMagnitude <= SumMagnitude;
                    end
                end
            end
        end else begin : gDelay
            localparam int PW = $clog2(DELAY + 1);
            localparam logic [PW-1:0] PRIME_FULL = PW'(DELAY);
            localparam logic [PW-1:0] PRIME_ONE  = PW'(1);

            logic [SW-1:0] delayLine_r [DELAY];
            logic [PW-1:0] primeCount_r;
            logic          outPulse_s;

            // The oldest entry leaves the line only once DELAY results are queued
            always_comb begin
                outPulse_s = v2_r & (primeCount_r == PRIME_FULL) & gateOk_s;
            end

            // Delay line shifts on every valid result; output samples its tail
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        delayLine_r[i] <= {SW{1'b0}};
                    end
                    primeCount_r <= {PW{1'b0}};
                    OutputEnable <= 1'b0;
                    SumMagnitude <= {SW{1'b0}};
                    WindowFull   <= 1'b0;
                end else begin
                    OutputEnable <= outPulse_s;
                    WindowFull   <= full2_r;
                    if (outPulse_s) begin
                        SumMagnitude <= delayLine_r[DELAY-1];
                    end else begin
                        SumMagnitude <= SumMagnitude;
                    end
                    if (v2_r) begin
                        for (int i = DELAY - 1; i > 0; i--) begin
                            delayLine_r[i] <= delayLine_r[i-1];
                        end
                        delayLine_r[0] <= acc_r;
                        if (primeCount_r != PRIME_FULL) begin
                            primeCount_r <= primeCount_r + PRIME_ONE;
                        end else begin
                            primeCount_r <= primeCount_r;
                        end
                    end else begin
                        primeCount_r <= primeCount_r;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_corr_window_energy_param.sv
module tb_corr_window_energy_param;

`ifdef CWE_WINDOW_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        InputEnable = 1'b0;
    logic [7:0]  DataInARe = 8'd0;
    logic [7:0]  DataInAIm = 8'd0;
    logic        oe0, oe4, full0, full4;
    logic [20:0] sum0, sum4;

    always #5 Clk = ~Clk;

    corr_window_energy_param #(.DW(8), .WIN_LOG2(4), .DELAY(0)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InputEnable(InputEnable),
        .DataInARe(DataInARe), .DataInAIm(DataInAIm),
        .OutputEnable(oe0), .SumMagnitude(sum0), .WindowFull(full0));

    corr_window_energy_param #(.DW(8), .WIN_LOG2(4), .DELAY(4)) dutD (
        .Clk(Clk), .Rst_n(Rst_n), .InputEnable(InputEnable),
        .DataInARe(DataInARe), .DataInAIm(DataInAIm),
        .OutputEnable(oe4), .SumMagnitude(sum4), .WindowFull(full4));

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    int lastSum0 = 0;
    int lastSum4 = 0;

    typedef struct { int sum; bit full; int due; } exp_t;
    exp_t exp0[$];
    exp_t exp4[$];
    int   hist[$];   // energies of every sample accepted since reset
    int   res[$];    // undelayed window sums in sample order

    typedef struct { bit rst; int re; int im; int sum; bit full; } vec_t;
    vec_t tbl[$];

    function automatic void check(string name, bit ok, int act, int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge Clk) edgeCnt <= edgeCnt + 1;

    // Reference model: the window sum is the plain sum of the last 16 energies.
    function automatic void modelPush(int re, int im);
        int s;
        int n;
        bit full;
        hist.push_back(re*re + im*im);
        n = hist.size();
        s = 0;
        for (int i = (n > 16) ? n - 16 : 0; i < n; i++) s += hist[i];
        full = (n >= 16);
        res.push_back(s);
        if (!GATE || full) exp0.push_back('{s, full, edgeCnt + 3});
        if (res.size() >= 5 && (!GATE || full))
            exp4.push_back('{res[res.size()-5], 1'b0, edgeCnt + 3});
    endfunction

    task automatic applySample(input bit en, input int re, input int im);
        @(posedge Clk);
        #1;
        InputEnable = en;
        DataInARe   = 8'(re);
        DataInAIm   = 8'(im);
        if (en) modelPush($signed(8'(re)), $signed(8'(im)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applySample(1'b0, 0, 0);
    endtask

    task automatic doReset();
        #2;
        Rst_n = 1'b0;
        InputEnable = 1'b0;
        exp0.delete(); exp4.delete(); hist.delete(); res.delete();
        lastSum0 = 0; lastSum4 = 0;
        #1;
        check("rst_oe0",   oe0 == 1'b0, int'(oe0), 0);
        check("rst_sum0",  sum0 == 21'd0, int'(sum0), 0);
        check("rst_full0", full0 == 1'b0, int'(full0), 0);
        check("rst_oe4",   oe4 == 1'b0, int'(oe4), 0);
        check("rst_sum4",  sum4 == 21'd0, int'(sum4), 0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    // Scoreboard: every pulse must match the model in value and cycle.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (exp0.size() > 0 && exp0[0].due < edgeCnt) begin
                check("d0_missing", 1'b0, 0, exp0[0].sum);
                void'(exp0.pop_front());
            end
            if (oe0) begin
                if (exp0.size() == 0) begin
                    check("d0_spurious", 1'b0, int'(sum0), -1);
                end else begin
                    check("d0_due",  exp0[0].due == edgeCnt, edgeCnt, exp0[0].due);
                    check("d0_sum",  int'(sum0) == exp0[0].sum, int'(sum0), exp0[0].sum);
                    check("d0_full", full0 == exp0[0].full, int'(full0), int'(exp0[0].full));
                    void'(exp0.pop_front());
                end
                lastSum0 = int'(sum0);
            end else begin
                check("d0_hold", int'(sum0) == lastSum0, int'(sum0), lastSum0);
            end
            if (exp4.size() > 0 && exp4[0].due < edgeCnt) begin
                check("d4_missing", 1'b0, 0, exp4[0].sum);
                void'(exp4.pop_front());
            end
            if (oe4) begin
                if (exp4.size() == 0) begin
                    check("d4_spurious", 1'b0, int'(sum4), -1);
                end else begin
                    check("d4_due", exp4[0].due == edgeCnt, edgeCnt, exp4[0].due);
                    check("d4_sum", int'(sum4) == exp4[0].sum, int'(sum4), exp4[0].sum);
                    void'(exp4.pop_front());
                end
                lastSum4 = int'(sum4);
            end else begin
                check("d4_hold", int'(sum4) == lastSum4, int'(sum4), lastSum4);
            end
        end
    end

    initial begin
        bit expOe;

        // Directed table: constant input, impulse-then-zero, and extremes.
        for (int k = 1; k <= 20; k++)
            tbl.push_back('{rst: (k == 1), re: 10, im: -5,
                            sum: 125 * ((k > 16) ? 16 : k), full: (k >= 16)});
        for (int k = 1; k <= 16; k++)
            tbl.push_back('{rst: (k == 1), re: 64, im: 0, sum: 4096 * k, full: (k == 16)});
        for (int j = 1; j <= 17; j++)
            tbl.push_back('{rst: 1'b0, re: 0, im: 0,
                            sum: 65536 - 4096 * ((j > 16) ? 16 : j), full: 1'b1});
        for (int k = 1; k <= 16; k++)
            tbl.push_back('{rst: (k == 1), re: -128, im: -128, sum: 32768 * k, full: (k == 16)});

        // Power-on reset state
        #1;
        check("por_oe0",  oe0 == 1'b0, int'(oe0), 0);
        check("por_sum0", sum0 == 21'd0, int'(sum0), 0);
        check("por_full", full0 == 1'b0, int'(full0), 0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].rst) doReset();
            applySample(1'b1, tbl[i].re, tbl[i].im);
            idle(3);
            expOe = !GATE || tbl[i].full;
            check("tbl_oe", oe0 == expOe, int'(oe0), int'(expOe));
            if (expOe) begin
                check("tbl_sum",  int'(sum0) == tbl[i].sum, int'(sum0), tbl[i].sum);
                check("tbl_full", full0 == tbl[i].full, int'(full0), int'(tbl[i].full));
            end
        end

        // Constant input at full rate: latency and ramp to 2000
        doReset();
        for (int k = 0; k < 20; k++) applySample(1'b1, 10, -5);
        idle(4);

        // Alternating InputEnable with random data
        doReset();
        for (int k = 0; k < 40; k++)
            applySample(k % 2 == 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        idle(4);

        // Ramp for the delayed instance
        doReset();
        for (int k = 1; k <= 12; k++) applySample(1'b1, k, 0);
        idle(4);

        // Random stream with random gaps
        doReset();
        for (int k = 0; k < 300; k++)
            applySample($urandom_range(0, 9) < 7,
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        idle(4);

        // Reset in mid-stream, then a single sample into an empty window
        doReset();
        for (int k = 0; k < 10; k++) applySample(1'b1, 7, -3);
        doReset();
        applySample(1'b1, 3, 4);
        idle(3);
        expOe = !GATE;
        check("post_rst_oe", oe0 == expOe, int'(oe0), int'(expOe));
        if (expOe) check("post_rst_sum", int'(sum0) == 25, int'(sum0), 25);
        check("post_rst_full", full0 == 1'b0, int'(full0), 0);
        idle(4);

        check("drain0", exp0.size() == 0, exp0.size(), 0);
        check("drain4", exp4.size() == 0, exp4.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
